// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: four execution units each feed a private 2-entry
// result FIFO; a round-robin arbiter drains one result per cycle onto the CDB.
module cdb_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [3:0]   req_valid,
    input  logic [127:0] req_data,
    input  logic [31:0]  req_phy,
    output logic [3:0]   req_ready,
    output logic         cdb_valid,
    output logic [31:0]  cdb_data,
    output logic [7:0]   cdb_phy,
    output logic [1:0]   cdb_src,
    output logic         drop_err
);

    localparam int unsigned N_UNITS = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PHY_W   = 8;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned SLOT_W  = 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PHY_W-1:0]  phy;
    } entry_t;

    entry_t             fifo_q  [N_UNITS][DEPTH];
    entry_t             fifo_d  [N_UNITS][DEPTH];
    logic [CNT_W-1:0]   count_q [N_UNITS];
    logic [CNT_W-1:0]   count_d [N_UNITS];
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;

    logic [N_UNITS-1:0] nonempty_c;
    logic [N_UNITS-1:0] push_c;
    logic [N_UNITS-1:0] pop_c;
    logic               grant_c;
    logic [PTR_W-1:0]   winner_c;
    logic [PTR_W-1:0]   scan_idx_c;
    logic [SLOT_W-1:0]  wr_slot_c;
    entry_t             in_entry_c;

    logic [N_UNITS-1:0] req_ready_d;
    logic               cdb_valid_d;
    logic [DATA_W-1:0]  cdb_data_d;
    logic [PHY_W-1:0]   cdb_phy_d;
    logic [PTR_W-1:0]   cdb_src_d;
    logic               drop_err_d;

    // Occupancy seen by the arbiter is the pre-edge count only.
    always_comb begin
        nonempty_c = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            nonempty_c[i] = (count_q[i] != '0);
        end
    end

    // Round-robin search starting at rr_ptr; flush suppresses any grant.
    always_comb begin
        grant_c    = 1'b0;
        winner_c   = rr_ptr_q;
        scan_idx_c = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            scan_idx_c = rr_ptr_q + PTR_W'(k);
            if (!grant_c && nonempty_c[scan_idx_c]) begin
                grant_c  = 1'b1;
                winner_c = scan_idx_c;
            end
        end
        if (flush) begin
            grant_c = 1'b0;
        end
    end

    // Per-unit FIFO update: pop shifts slot 1 into the head, push lands
    // behind whatever survives the pop.
    always_comb begin
        fifo_d      = fifo_q;
        count_d     = count_q;
        push_c      = '0;
        pop_c       = '0;
        wr_slot_c   = '0;
        in_entry_c  = '0;
        req_ready_d = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            push_c[i] = req_valid[i] & req_ready[i] & ~flush;
            pop_c[i]  = grant_c && (winner_c == PTR_W'(i));
            in_entry_c.data = req_data[i*DATA_W +: DATA_W];
            in_entry_c.phy  = req_phy[i*PHY_W +: PHY_W];
            wr_slot_c = SLOT_W'((count_q[i] != '0) && !pop_c[i]);
            if (pop_c[i]) begin
                fifo_d[i][0] = fifo_q[i][1];
            end
            if (push_c[i]) begin
                fifo_d[i][wr_slot_c] = in_entry_c;
            end
            if (flush) begin
                count_d[i] = '0;
            end else begin
                count_d[i] = count_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop_c[i]);
            end
            req_ready_d[i] = (count_d[i] < CNT_W'(DEPTH));
        end
    end

    // CDB payload holds its last value when nothing is granted.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_c;
        cdb_data_d  = cdb_data;
        cdb_phy_d   = cdb_phy;
        cdb_src_d   = cdb_src;
        drop_err_d  = drop_err | ((|(req_valid & ~req_ready)) & ~flush);
        if (grant_c) begin
            rr_ptr_d   = winner_c + PTR_W'(1);
            cdb_data_d = fifo_q[winner_c][0].data;
            cdb_phy_d  = fifo_q[winner_c][0].phy;
            cdb_src_d  = winner_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_UNITS; i++) begin
                count_q[i] <= '0;
            end
            rr_ptr_q  <= '0;
            req_ready <= '1;
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_phy   <= '0;
            cdb_src   <= '0;
            drop_err  <= 1'b0;
        end else begin
            count_q   <= count_d;
            rr_ptr_q  <= rr_ptr_d;
            req_ready <= req_ready_d;
            cdb_valid <= cdb_valid_d;
            cdb_data  <= cdb_data_d;
            cdb_phy   <= cdb_phy_d;
            cdb_src   <= cdb_src_d;
            drop_err  <= drop_err_d;
        end
    end

    // Payload storage needs no reset: the counts decide what is live.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [31:0]  req_phy;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [31:0]  cdb_data;
    logic [7:0]   cdb_phy;
    logic [1:0]   cdb_src;
    logic         drop_err;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_phy   (req_phy),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_phy   (cdb_phy),
        .cdb_src   (cdb_src),
        .drop_err  (drop_err)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  p;
    } ent_t;

    typedef struct {
        logic         r;
        logic         f;
        logic [3:0]   v;
        logic [127:0] d;
        logic [31:0]  p;
        logic         e_valid;
        logic [31:0]  e_data;
        logic [7:0]   e_phy;
        logic [1:0]   e_src;
        logic [3:0]   e_ready;
        logic         e_drop;
    } vec_t;

    // Reference model: one queue per unit plus a round-robin start index.
    ent_t        mq[4][$];
    int          m_rr;
    logic        m_valid;
    logic [31:0] m_data;
    logic [7:0]  m_phy;
    logic [1:0]  m_src;
    logic        m_drop;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic [3:0] v,
                                input logic [127:0] d, input logic [31:0] p);
        int   w;
        bit   [3:0] rdy;
        ent_t e;
        if (r) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr = 0; m_valid = 1'b0; m_data = '0; m_phy = '0; m_src = '0; m_drop = 1'b0;
        end else if (f) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_valid = 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < 4; k++)
                if (w < 0 && mq[(m_rr + k) % 4].size() != 0) w = (m_rr + k) % 4;
            for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() < 2);
            if (w >= 0) begin
                e = mq[w].pop_front();
                m_valid = 1'b1; m_data = e.d; m_phy = e.p; m_src = 2'(w);
                m_rr = (w + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i]) begin
                    if (rdy[i]) begin
                        e.d = d[32*i +: 32];
                        e.p = p[8*i +: 8];
                        mq[i].push_back(e);
                    end else begin
                        m_drop = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [3:0] model_ready();
        logic [3:0] rd;
        for (int i = 0; i < 4; i++) rd[i] = (mq[i].size() < 2);
        return rd;
    endfunction

    task automatic compare_model();
        check("model cdb_valid", 32'(cdb_valid), 32'(m_valid));
        check("model cdb_data",  cdb_data,        m_data);
        check("model cdb_phy",   32'(cdb_phy),    32'(m_phy));
        check("model cdb_src",   32'(cdb_src),    32'(m_src));
        check("model req_ready", 32'(req_ready),  32'(model_ready()));
        check("model drop_err",  32'(drop_err),   32'(m_drop));
    endtask

    task automatic step(input logic r, input logic f, input logic [3:0] v,
                        input logic [127:0] d, input logic [31:0] p);
        rst = r; flush = f; req_valid = v; req_data = d; req_phy = p;
        @(posedge clk);
        model_update(r, f, v, d, p);
        #1;
        compare_model();
    endtask

    task automatic add_vec(input logic r, input logic f, input logic [3:0] v,
                           input logic [127:0] d, input logic [31:0] p,
                           input logic ev, input logic [31:0] edata, input logic [7:0] ephy,
                           input logic [1:0] esrc, input logic [3:0] erdy, input logic edrop);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.d = d; x.p = p;
        x.e_valid = ev; x.e_data = edata; x.e_phy = ephy; x.e_src = esrc;
        x.e_ready = erdy; x.e_drop = edrop;
        vecs.push_back(x);
    endtask

    initial begin
        logic [7:0]   mul_exp[$];
        logic [7:0]   mul_got[$];
        logic [7:0]   flushed[$];
        logic [7:0]   nxt_phy;
        logic [3:0]   v;
        logic [127:0] d;
        logic [31:0]  p;
        int           alu_push;
        int           alu_seen;
        bit           mul_full_seen;
        bit           setup_ok;
        bit           stale_seen;
        bit           stale_valid;

        // Single ALU result, then all four from reset, then the DIV-drop case.
        add_vec(1, 0, 4'h0, 128'h0, 32'h0, 0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h1, 128'hAA, 32'h12, 0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'hAA, 8'h12, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 0, 32'hAA, 8'h12, 2'd0, 4'hF, 0);
        add_vec(1, 0, 4'h0, 128'h0, 32'h0, 0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'hF, {32'h103, 32'h102, 32'h101, 32'h100}, {8'h23, 8'h22, 8'h21, 8'h20},
                0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h100, 8'h20, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h101, 8'h21, 2'd1, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h102, 8'h22, 2'd2, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h103, 8'h23, 2'd3, 4'hF, 0);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 0, 32'h103, 8'h23, 2'd3, 4'hF, 0);
        add_vec(1, 0, 4'h0, 128'h0, 32'h0, 0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'hB, {32'h303, 32'h0, 32'h301, 32'h300}, {8'h33, 8'h00, 8'h31, 8'h30},
                0, 32'h0, 8'h00, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h4, {32'h0, 32'h400, 64'h0}, {8'h00, 8'h40, 16'h0},
                1, 32'h300, 8'h30, 2'd0, 4'hF, 0);
        add_vec(0, 0, 4'h4, {32'h0, 32'h401, 64'h0}, {8'h00, 8'h41, 16'h0},
                1, 32'h301, 8'h31, 2'd1, 4'hB, 0);
        add_vec(0, 0, 4'h4, {32'h0, 32'h402, 64'h0}, {8'h00, 8'h42, 16'h0},
                1, 32'h400, 8'h40, 2'd2, 4'hF, 1);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h303, 8'h33, 2'd3, 4'hF, 1);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 1, 32'h401, 8'h41, 2'd2, 4'hF, 1);
        add_vec(0, 0, 4'h0, 128'h0, 32'h0, 0, 32'h401, 8'h41, 2'd2, 4'hF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].p);
            check($sformatf("vec%0d cdb_valid", i), 32'(cdb_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d cdb_data", i),  cdb_data,       vecs[i].e_data);
            check($sformatf("vec%0d cdb_phy", i),   32'(cdb_phy),   32'(vecs[i].e_phy));
            check($sformatf("vec%0d cdb_src", i),   32'(cdb_src),   32'(vecs[i].e_src));
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d drop_err", i),  32'(drop_err),  32'(vecs[i].e_drop));
        end

        // MUL streams while it has room; ALU cuts in once.
        step(1, 0, 4'h0, 128'h0, 32'h0);
        nxt_phy = 8'h60; alu_push = -1; alu_seen = -1; mul_full_seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            v = 4'h0; d = '0; p = '0;
            if (c < 10 && mq[1].size() < 2) begin
                v[1] = 1'b1; d[63:32] = 32'h6000 + 32'(nxt_phy); p[15:8] = nxt_phy;
                mul_exp.push_back(nxt_phy); nxt_phy++;
            end
            if (c == 4) begin
                v[0] = 1'b1; d[31:0] = 32'hA5A5; p[7:0] = 8'hA5; alu_push = c;
            end
            step(0, 0, v, d, p);
            if (mq[1].size() == 2) mul_full_seen = 1'b1;
            if (cdb_valid && cdb_src == 2'd1) mul_got.push_back(cdb_phy);
            if (cdb_valid && cdb_src == 2'd0 && cdb_phy == 8'hA5 && alu_seen < 0) alu_seen = c;
        end
        check("alu granted within 2", 32'(alu_seen > alu_push && alu_seen - alu_push <= 2), 32'd1);
        check("mul reached 2 entries", 32'(mul_full_seen), 32'd1);
        check("mul result count", 32'(mul_got.size()), 32'(mul_exp.size()));
        for (int i = 0; i < mul_exp.size() && i < mul_got.size(); i++)
            check($sformatf("mul order %0d", i), 32'(mul_got[i]), 32'(mul_exp[i]));
        check("mul stream drop_err", 32'(drop_err), 32'd0);

        // Fill MUL and DIV to two entries each, then flush.
        step(1, 0, 4'h0, 128'h0, 32'h0);
        nxt_phy = 8'h80; setup_ok = 1'b0;
        for (int c = 0; c < 20 && !setup_ok; c++) begin
            if (mq[1].size() == 2 && mq[2].size() == 2) begin
                setup_ok = 1'b1;
            end else begin
                v = 4'h0; d = '0; p = '0;
                for (int u = 0; u < 4; u++) begin
                    if (mq[u].size() < 2) begin
                        v[u] = 1'b1; d[32*u +: 32] = 32'h8000 + 32'(nxt_phy);
                        p[8*u +: 8] = nxt_phy; nxt_phy++;
                    end
                end
                step(0, 0, v, d, p);
            end
        end
        check("flush setup reached", 32'(setup_ok), 32'd1);
        for (int u = 0; u < 4; u++)
            for (int k = 0; k < mq[u].size(); k++) flushed.push_back(mq[u][k].p);
        v = model_ready(); p = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        for (int u = 0; u < 4; u++) if (v[u]) flushed.push_back(p[8*u +: 8]);
        step(0, 1, v, 128'h0, p);
        check("flush cdb_valid", 32'(cdb_valid), 32'd0);
        check("flush req_ready", 32'(req_ready), 32'hF);
        stale_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 4'h0, 128'h0, 32'h0);
            if (cdb_valid)
                foreach (flushed[j]) if (flushed[j] == cdb_phy) stale_seen = 1'b1;
        end
        check("flushed phy never on cdb", 32'(stale_seen), 32'd0);

        // Reset (with flush also high) while entries are queued.
        step(0, 0, 4'hF, {4{32'hCAFE}}, 32'h91929394);
        step(0, 0, 4'hF, {4{32'hBEEF}}, 32'hA1A2A3A4);
        step(1, 1, 4'hF, {4{32'hDEAD}}, 32'hB1B2B3B4);
        check("rst cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst cdb_data",  cdb_data,       32'd0);
        check("rst cdb_phy",   32'(cdb_phy),   32'd0);
        check("rst cdb_src",   32'(cdb_src),   32'd0);
        check("rst req_ready", 32'(req_ready), 32'hF);
        check("rst drop_err",  32'(drop_err),  32'd0);
        stale_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 4'h0, 128'h0, 32'h0);
            if (cdb_valid) stale_valid = 1'b1;
        end
        check("no stale cdb_valid after rst", 32'(stale_valid), 32'd0);

        // Random traffic against the model.
        step(1, 0, 4'h0, 128'h0, 32'h0);
        for (int c = 0; c < 1500; c++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
                 4'($urandom & $urandom), d, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
